// File: rtl/win_scan_ctrl_pkg.sv
// Shared constants and FSM encoding for the
// 3x3 window scan controller.
package win_scan_ctrl_pkg;

  localparam int IMG_W     = 256;
  localparam int IMG_H     = 32;
  localparam int PAD_W     = IMG_W + 2;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int PIPE_LAT  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/win_scan_ctrl_valid_delay.sv
// Valid delay line: a read strobe re-emerges
// DEPTH cycles later as the matching result strobe.
module valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // Shift the strobe one stage per cycle; reset drops in-flight windows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/win_scan_ctrl.sv
// Raster scan controller: issues one padded 3x3
// window read per cycle and writes filter results back.
module win_scan_ctrl #(
  parameter int IMG_W    = win_scan_ctrl_pkg::IMG_W,
  parameter int IMG_H    = win_scan_ctrl_pkg::IMG_H,
  parameter int PAD_W    = win_scan_ctrl_pkg::PAD_W,
  parameter int PIPE_LAT = win_scan_ctrl_pkg::PIPE_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  output logic        rd_en,
  output logic [13:0] rd_base,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic        busy,
  output logic        done
);

  import win_scan_ctrl_pkg::*;

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NPIX = IMG_W * IMG_H;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [13:0]   WRAP_STEP = 14'(PAD_W - IMG_W + 1);
  localparam logic [12:0]   ADDR_LAST = 13'(NPIX - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [13:0]   base;
  logic          kick;
  logic          issue;
  logic          last_issue;
  logic          last_write;
  logic          wr_vld;

  assign kick       = (state == S_IDLE) && start;
  assign issue      = (state == S_RUN) && !pause;
  assign last_issue = issue && (col == COL_LAST)
                      && (row == ROW_LAST);
  assign last_write = wr_vld && (wr_addr == ADDR_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start)      state_nx = S_RUN;
      S_RUN:   if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (last_write) state_nx = S_DONE;
      S_DONE:                  state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Raster position; base tracks row*PAD_W+col by increments
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      base <= '0;
    end else if (kick) begin
      col  <= '0;
      row  <= '0;
      base <= '0;
    end else if (issue) begin
      if (col == COL_LAST) begin
        col  <= '0;
        row  <= row + 1'b1;
        base <= base + WRAP_STEP;
      end else begin
        col  <= col + 1'b1;
        base <= base + 14'd1;
      end
    end
  end

  // Registered read strobe and address of the issued window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_base <= '0;
    end else begin
      rd_en <= issue;
      if (kick) begin
        rd_base <= '0;
      end else if (issue) begin
        rd_base <= base;
      end
    end
  end

  valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rd_en),
    .dout  (wr_vld)
  );

  assign wr_en = wr_vld;

  // Result address advances once per completed write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= '0;
    end else if (kick) begin
      wr_addr <= '0;
    end else if (wr_vld) begin
      wr_addr <= wr_addr + 13'd1;
    end
  end

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Self-checking bench for win_scan_ctrl: random pause/start
// stimulus checked against a frame-level reference model.
module tb_win_scan_ctrl;

  localparam int IMG_W = 256;
  localparam int IMG_H = 32;
  localparam int PAD_W = 258;
  localparam int LAT   = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int BOUND = 3 * NPIX;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        rd_en;
  logic [13:0] rd_base;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic        busy;
  logic        done;

  win_scan_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pause   (pause),
    .rd_en   (rd_en),
    .rd_base (rd_base),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  int rd_cyc[$];
  int rd_adr[$];
  int wr_cyc[$];
  int wr_adr[$];
  int dn_cyc[$];
  bit pv[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its cycle relative to the start edge
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_cyc.push_back(cyc - t0);
      rd_adr.push_back(int'(rd_base));
    end
    if (wr_en === 1'b1) begin
      wr_cyc.push_back(cyc - t0);
      wr_adr.push_back(int'(wr_addr));
    end
    if (done === 1'b1) dn_cyc.push_back(cyc - t0);
  end

  function automatic int base_of(int k);
    return (k / IMG_W) * PAD_W + (k % IMG_W);
  endfunction

  task automatic clear_mon();
    rd_cyc.delete();
    rd_adr.delete();
    wr_cyc.delete();
    wr_adr.delete();
    dn_cyc.delete();
  endtask

  // mode 0: no pause, 1: 10-cycle pause at edge 1000
  // plus pause noise in drain, 2: random pause
  task automatic run_frame(input int mode, input bit noise,
                           output int done_rel);
    int rel;
    int mreads;
    int hold_err;
    int exp_rd[$];
    int nr;
    int nw;
    int bad;
    int k;
    int exp_done;
    bit p;
    @(posedge clk);
    #1;
    clear_mon();
    t0    = cyc + 1;
    start = 1'b1;
    pause = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rel      = 0;
    done_rel = -1;
    mreads   = 0;
    hold_err = 0;
    pv.delete();
    pv.push_back(1'b0);
    while (rel < BOUND) begin
      p = 1'b0;
      if (mode == 1) begin
        p = (rel + 1 >= 1000) && (rel + 1 <= 1009);
        if (mreads >= NPIX) p = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        p = ($urandom_range(0, 7) == 0);
      end
      pv.push_back(p);
      if (!p && mreads < NPIX) mreads++;
      pause = p;
      start = noise && (busy || done)
              && ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
      rel++;
      if (mode == 1 && rel >= 1000 && rel <= 1009) begin
        if (rd_en !== 1'b0 || int'(rd_base) != base_of(998))
          hold_err++;
      end
      if (done === 1'b1) begin
        done_rel = rel;
        break;
      end
    end
    start = 1'b0;
    pause = 1'b0;
    checks++;
    if (done_rel < 0) begin
      errors++;
      $display("FAIL frame_timeout: done=%0d required=1", 0);
    end
    for (int r = 1; r < pv.size(); r++) begin
      if (exp_rd.size() < NPIX && !pv[r]) exp_rd.push_back(r);
    end
    nr = rd_cyc.size();
    checks++;
    if (nr != NPIX) begin
      errors++;
      $display("FAIL read_count: got %0d required %0d", nr, NPIX);
    end
    bad = -1;
    for (k = 0; k < nr && k < exp_rd.size(); k++) begin
      if (rd_cyc[k] != exp_rd[k] || rd_adr[k] != base_of(k)) begin
        bad = k;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL read_seq #%0d: cyc %0d base %0d required cyc %0d base %0d",
               bad, rd_cyc[bad], rd_adr[bad], exp_rd[bad], base_of(bad));
    end
    nw = wr_cyc.size();
    checks++;
    if (nw != NPIX) begin
      errors++;
      $display("FAIL write_count: got %0d required %0d", nw, NPIX);
    end
    bad = -1;
    for (k = 0; k < nw && k < exp_rd.size(); k++) begin
      if (wr_cyc[k] != exp_rd[k] + LAT || wr_adr[k] != k) begin
        bad = k;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL write_seq #%0d: cyc %0d addr %0d required cyc %0d addr %0d",
               bad, wr_cyc[bad], wr_adr[bad], exp_rd[bad] + LAT, bad);
    end
    exp_done = (exp_rd.size() == NPIX) ? exp_rd[NPIX-1] + LAT + 1 : -2;
    checks++;
    if (done_rel != exp_done) begin
      errors++;
      $display("FAIL done_time: got %0d required %0d", done_rel, exp_done);
    end
    if (mode == 1) begin
      checks++;
      if (hold_err != 0) begin
        errors++;
        $display("FAIL pause_hold: bad cycles %0d required 0", hold_err);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dn_cyc.size() != 1) begin
      errors++;
      $display("FAIL after_done: busy %b done %b pulses %0d required 0 0 1",
               busy, done, dn_cyc.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, wr_en, busy, done, rd_base, wr_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: rd_en %b wr_en %b busy %b done %b base %0d addr %0d required all 0",
               rd_en, wr_en, busy, done, rd_base, wr_addr);
    end
    rst_n = 1'b1;
    pause = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pause = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy %b rd_en %b required 0 0", busy, rd_en);
    end
  endtask

  task automatic test_frame_basic();
    int d;
    run_frame(0, 1'b0, d);
    checks++;
    if (d != NPIX + LAT + 1) begin
      errors++;
      $display("FAIL frame_latency: got %0d required %0d", d, NPIX + LAT + 1);
    end
    checks++;
    if (rd_adr.size() != NPIX || rd_adr[255] != 255 || rd_adr[256] != 258
        || rd_adr[NPIX-1] != 8253) begin
      errors++;
      $display("FAIL row_wrap: reads %0d required 8192 with 255/258/8253",
               rd_adr.size());
    end
  endtask

  task automatic test_pause_mid_row();
    int d;
    run_frame(1, 1'b1, d);
    checks++;
    if (d != NPIX + LAT + 1 + 10) begin
      errors++;
      $display("FAIL pause_delay: got %0d required %0d", d, NPIX + LAT + 11);
    end
  endtask

  task automatic test_random_pause();
    int d;
    run_frame(2, 1'b1, d);
  endtask

  task automatic test_reset_mid_frame();
    int d;
    int strays;
    @(posedge clk);
    #1;
    clear_mon();
    t0    = cyc + 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4001) @(posedge clk);
    #1;
    checks++;
    if (rd_en !== 1'b1 || int'(rd_base) != base_of(4000)) begin
      errors++;
      $display("FAIL read_4000: rd_en %b base %0d required 1 %0d",
               rd_en, rd_base, base_of(4000));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({rd_en, wr_en, busy, done, rd_base, wr_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rd_en %b wr_en %b busy %b done %b base %0d addr %0d required all 0",
               rd_en, wr_en, busy, done, rd_base, wr_addr);
    end
    strays = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) strays++;
    end
    checks++;
    if (strays != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: active cycles %0d required 0", strays);
    end
    run_frame(0, 1'b0, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_basic();
    test_pause_mid_row();
    test_random_pause();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
